// File: rtl/eep_bram_arb_pkg.sv
// eep_arb_pkg: shared definitions for the save-BRAM arbiter.
//   - arb_state_t : access sequencer states (IDLE -> ISSUE -> DONE)
//   - REQ_*       : requester indices (bit positions in req/we/ack)
//   - BRAM_AW     : BRAM address width (512 x 8 save RAM)
//   - next_req    : round-robin successor of a requester index
package eep_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_EEP0 = 2'd0;
    localparam logic [1:0] REQ_EEP1 = 2'd1;
    localparam logic [1:0] REQ_HOST = 2'd2;
    localparam int         NREQ     = 3;
    localparam int         BRAM_AW  = 9;

    // Successor in the order 0, 1, 2, wrap. The unused code 3 maps to 0.
    function automatic logic [1:0] next_req(input logic [1:0] r);
        return (r >= 2'd2) ? 2'd0 : r + 2'd1;
    endfunction

endpackage

// File: rtl/eep_bram_arb_if.sv
// eep_bram_arb_if: requester and BRAM signals of the save-BRAM arbiter.
//   Requester side: req/we (per requester), eep0_addr, eep1_addr, host_addr,
//                   wdat0..2 in; ack (per requester) and shared rdat out.
//   BRAM side     : bram_addr/bram_we/bram_di out, bram_do in (1-cycle read).
//   slave  modport: the arbiter.
//   master modport: requesters plus the BRAM that sits behind the arbiter.
interface eep_bram_arb_if;
    import eep_arb_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [7:0]         eep0_addr;
    logic [7:0]         eep1_addr;
    logic [BRAM_AW-1:0] host_addr;
    logic [7:0]         wdat0;
    logic [7:0]         wdat1;
    logic [7:0]         wdat2;
    logic [NREQ-1:0]    ack;
    logic [7:0]         rdat;
    logic [BRAM_AW-1:0] bram_addr;
    logic               bram_we;
    logic [7:0]         bram_di;
    logic [7:0]         bram_do;

    modport slave (
        input  req, we, eep0_addr, eep1_addr, host_addr, wdat0, wdat1, wdat2, bram_do,
        output ack, rdat, bram_addr, bram_we, bram_di
    );

    modport master (
        output req, we, eep0_addr, eep1_addr, host_addr, wdat0, wdat1, wdat2, bram_do,
        input  ack, rdat, bram_addr, bram_we, bram_di
    );

endinterface

// File: rtl/eep_bram_arb_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//   eligible : requesters that may be granted now
//   last_gnt : most recent grant; the search starts at its successor
//   valid    : some requester is eligible
//   idx      : chosen requester
// HOST_PRIO=1 lets the host (index 2) win whenever eligible; the caller then
// feeds last_gnt with the last eep grant so eep0/eep1 alternate cleanly.
module rr_pick3
    import eep_arb_pkg::*;
#(
    parameter bit HOST_PRIO = 1'b0
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [1:0]      last_gnt,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand0 = next_req(last_gnt);
    assign cand1 = next_req(cand0);
    assign cand2 = next_req(cand1);
    assign valid = |eligible;

    always_comb begin
        idx = REQ_EEP0;
        if (HOST_PRIO && eligible[REQ_HOST]) begin
            idx = REQ_HOST;
        end else begin
            // Farthest candidate first so the nearest eligible one overrides.
            if (eligible[cand2]) idx = cand2;
            if (eligible[cand1]) idx = cand1;
            if (eligible[cand0]) idx = cand0;
        end
    end

endmodule

// File: rtl/eep_bram_arb.sv
// eep_bram_arb: arbitrates one single-port 512x8 save BRAM between the
// internal 24C02 emulator (eep0, bank 0), the external 24X01 emulator
// (eep1, bank 1) and the host save-state port. One access is in flight at a
// time: IDLE/DONE pick a requester, ISSUE presents it to the BRAM, DONE
// returns ack[gnt] with rdat = bram_do. Throughput is one access per 2 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : eep_bram_arb_if.slave (requester handshake + BRAM port)
//   dirty      : (EEP_DIRTY_TRACK_EN only) per-bank "eep wrote here" flags
//   dirty_clr  : (EEP_DIRTY_TRACK_EN only) per-bank clear pulses
// Parameters: EEP1_AMASK masks the bank-1 address; HOST_PRIO=1 gives the
// host fixed top priority instead of joining the round-robin.
module eep_bram_arb
    import eep_arb_pkg::*;
#(
    parameter logic [7:0] EEP1_AMASK = 8'hFF,
    parameter bit         HOST_PRIO  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef EEP_DIRTY_TRACK_EN
    output logic [1:0] dirty,
    input  logic [1:0] dirty_clr,
`endif
    eep_bram_arb_if.slave bus
);

    arb_state_t         state_reg, state_next;
    logic [1:0]         gnt_reg;
    logic [1:0]         last_gnt_reg;
    logic               last_eep_reg;
    logic [BRAM_AW-1:0] bram_addr_reg;
    logic               bram_we_reg;
    logic [7:0]         bram_di_reg;

    logic [NREQ-1:0]    eligible;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [1:0]         pick_last;
    logic               grant_go;
    logic [BRAM_AW-1:0] sel_addr;
    logic               sel_we;
    logic [7:0]         sel_di;

    // The grantee still holds req during its ack cycle, so it is masked in DONE.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign eligible[gi] = bus.req[gi] & ~((state_reg == DONE) & (gnt_reg == 2'(gi)));
        assign bus.ack[gi]  = (state_reg == DONE) & (gnt_reg == 2'(gi));
    end

    // With host priority the host never takes a round-robin turn, so the
    // eep pair rotates on its own history.
    assign pick_last = HOST_PRIO ? {1'b0, last_eep_reg} : last_gnt_reg;

    rr_pick3 #(.HOST_PRIO(HOST_PRIO)) u_pick (
        .eligible (eligible),
        .last_gnt (pick_last),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        sel_addr = bus.host_addr;
        sel_we   = bus.we[REQ_HOST];
        sel_di   = bus.wdat2;
        case (pick_idx)
            REQ_EEP0: begin
                sel_addr = {1'b0, bus.eep0_addr};
                sel_we   = bus.we[REQ_EEP0];
                sel_di   = bus.wdat0;
            end
            REQ_EEP1: begin
                sel_addr = {1'b1, bus.eep1_addr & EEP1_AMASK};
                sel_we   = bus.we[REQ_EEP1];
                sel_di   = bus.wdat1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        grant_go   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                    grant_go   = 1'b1;
                end
            end
            ISSUE: state_next = DONE;
            DONE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                    grant_go   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= REQ_EEP0;
            last_gnt_reg  <= REQ_HOST;
            last_eep_reg  <= 1'b1;
            bram_addr_reg <= '0;
            bram_we_reg   <= 1'b0;
            bram_di_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_go) begin
                gnt_reg       <= pick_idx;
                last_gnt_reg  <= pick_idx;
                bram_addr_reg <= sel_addr;
                bram_we_reg   <= sel_we;
                bram_di_reg   <= sel_di;
                if (pick_idx != REQ_HOST) last_eep_reg <= pick_idx[0];
            end
        end
    end

    // bram_we_reg lingers into DONE; the state gate keeps the strobe to ISSUE.
    assign bus.bram_we   = bram_we_reg & (state_reg == ISSUE);
    assign bus.bram_addr = bram_addr_reg;
    assign bus.bram_di   = bram_di_reg;
    assign bus.rdat      = bus.bram_do;

`ifdef EEP_DIRTY_TRACK_EN
    logic [1:0] dirty_reg;
    logic [1:0] dirty_set;

    // Only eep requesters 0/1 map to banks 0/1; host grants never match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dirty
        assign dirty_set[gi] = (state_reg == ISSUE) & bram_we_reg & (gnt_reg == 2'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_reg <= '0;
        end else begin
            dirty_reg <= dirty_set | (dirty_reg & ~dirty_clr);
        end
    end

    assign dirty = dirty_reg;
`endif

endmodule

// File: tb/tb_eep_bram_arb.sv
module tb_eep_bram_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eep_bram_arb_if bus_a ();
    eep_bram_arb_if bus_b ();

`ifdef EEP_DIRTY_TRACK_EN
    logic [1:0] dirty_a, dirty_b;
    logic [1:0] dirty_clr_a = 2'b00;
    logic [1:0] dirty_clr_b = 2'b00;
`endif

    eep_bram_arb #(.EEP1_AMASK(8'h7F), .HOST_PRIO(1'b0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef EEP_DIRTY_TRACK_EN
        .dirty     (dirty_a),
        .dirty_clr (dirty_clr_a),
`endif
        .bus       (bus_a)
    );

    eep_bram_arb #(.EEP1_AMASK(8'hFF), .HOST_PRIO(1'b1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef EEP_DIRTY_TRACK_EN
        .dirty     (dirty_b),
        .dirty_clr (dirty_clr_b),
`endif
        .bus       (bus_b)
    );

    // BRAM models: 1-cycle read latency, read-before-write.
    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];
    int we_cnt_a = 0;

    always @(posedge clk) begin
        if (bus_a.bram_we) begin
            mem_a[bus_a.bram_addr] <= bus_a.bram_di;
            we_cnt_a++;
        end
        bus_a.bram_do <= mem_a[bus_a.bram_addr];
        if (bus_b.bram_we) mem_b[bus_b.bram_addr] <= bus_b.bram_di;
        bus_b.bram_do <= mem_b[bus_b.bram_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         idx;
        bit         chk_dat;
        logic [7:0] dat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Scoreboard monitors: every ack must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_a.ack != 3'b000) begin
            if (q_a.size() == 0) begin
                chk_val("a_spurious_ack", {29'b0, bus_a.ack}, 32'h0);
            end else begin
                e = q_a.pop_front();
                $display("[%0t] a ack=%b rdat=%02h exp_idx=%0d", $time, bus_a.ack, bus_a.rdat, e.idx);
                chk_val("a_ack_idx", {29'b0, bus_a.ack}, 32'(1 << e.idx));
                if (e.chk_dat) chk_val("a_rdat", {24'b0, bus_a.rdat}, {24'b0, e.dat});
            end
        end
        if (rst_n && bus_b.ack != 3'b000) begin
            if (q_b.size() == 0) begin
                chk_val("b_spurious_ack", {29'b0, bus_b.ack}, 32'h0);
            end else begin
                e = q_b.pop_front();
                $display("[%0t] b ack=%b exp_idx=%0d", $time, bus_b.ack, e.idx);
                chk_val("b_ack_idx", {29'b0, bus_b.ack}, 32'(1 << e.idx));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated request on dut_a; checks ISSUE outputs, latency, we pulses.
    task automatic txn_a(input int idx, input bit wr, input logic [8:0] addr,
                         input logic [7:0] wd, input logic [8:0] exp_addr,
                         input bit chk, input logic [7:0] exp_rd, input bit clr0);
        int wc0;
        int lat;
        @(negedge clk);
        wc0 = we_cnt_a;
        bus_a.req = 3'b000;
        bus_a.we  = 3'b000;
        bus_a.req[idx] = 1'b1;
        bus_a.we[idx]  = wr;
        case (idx)
            0:       begin bus_a.eep0_addr = addr[7:0]; bus_a.wdat0 = wd; end
            1:       begin bus_a.eep1_addr = addr[7:0]; bus_a.wdat1 = wd; end
            default: begin bus_a.host_addr = addr;      bus_a.wdat2 = wd; end
        endcase
        q_a.push_back('{idx: idx, chk_dat: chk, dat: exp_rd});
        @(negedge clk);
        chk_val("a_issue_addr", {23'b0, bus_a.bram_addr}, {23'b0, exp_addr});
        chk_val("a_issue_we", {31'b0, bus_a.bram_we}, {31'b0, wr});
        if (wr) chk_val("a_issue_di", {24'b0, bus_a.bram_di}, {24'b0, wd});
`ifdef EEP_DIRTY_TRACK_EN
        if (clr0) dirty_clr_a = 2'b01;
`else
        if (clr0) lat = 0;
`endif
        lat = 1;
        while (bus_a.ack[idx] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
`ifdef EEP_DIRTY_TRACK_EN
        dirty_clr_a = 2'b00;
`endif
        chk_val("a_latency", lat, 2);
        bus_a.req = 3'b000;
        bus_a.we  = 3'b000;
        repeat (2) @(negedge clk);
        chk_val("a_we_pulses", we_cnt_a - wc0, {31'b0, wr});
    endtask

    initial begin
        int n;
        int cyc;
        int prev;
        bus_a.req = 0; bus_a.we = 0; bus_a.eep0_addr = 0; bus_a.eep1_addr = 0;
        bus_a.host_addr = 0; bus_a.wdat0 = 0; bus_a.wdat1 = 0; bus_a.wdat2 = 0;
        bus_b.req = 0; bus_b.we = 0; bus_b.eep0_addr = 0; bus_b.eep1_addr = 0;
        bus_b.host_addr = 0; bus_b.wdat0 = 0; bus_b.wdat1 = 0; bus_b.wdat2 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_val("rst_ack", {29'b0, bus_a.ack}, 32'h0);
        chk_val("rst_we", {31'b0, bus_a.bram_we}, 32'h0);
        chk_val("rst_addr", {23'b0, bus_a.bram_addr}, 32'h0);
        chk_val("rst_di", {24'b0, bus_a.bram_di}, 32'h0);
        chk_val("rst_ack_b", {29'b0, bus_b.ack}, 32'h0);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("rst_dirty", {30'b0, dirty_a}, 32'h0);
`endif
        rst_n = 1'b1;

        // HOST_PRIO=1: eep0/eep1 held, host pulses every 4 cycles.
        foreach (q_b[i]) q_b.delete(i);
        begin
            int seq [8] = '{0, 1, 2, 0, 2, 1, 2, 0};
            foreach (seq[i]) q_b.push_back('{idx: seq[i], chk_dat: 1'b0, dat: 8'h00});
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus_b.req[0] = (c < 16);
            bus_b.req[1] = (c < 16);
            bus_b.req[2] = (c >= 4 && c < 6) || (c >= 8 && c < 10) || (c >= 12 && c < 14);
        end
        chk_val("b_all_acks", q_b.size(), 0);

        // Directed single accesses on dut_a (EEP1_AMASK = 8'h7F).
        txn_a(2, 1'b1, 9'h010, 8'hA5, 9'h010, 1'b0, 8'h00, 1'b0);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("dirty_host_w0", {30'b0, dirty_a}, 32'h0);
`endif
        txn_a(0, 1'b0, 9'h010, 8'h00, 9'h010, 1'b1, 8'hA5, 1'b0);
        txn_a(1, 1'b1, 9'h0C3, 8'h5A, 9'h143, 1'b0, 8'h00, 1'b0);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("dirty_eep1_w", {30'b0, dirty_a}, 32'h2);
`endif
        txn_a(2, 1'b0, 9'h143, 8'h00, 9'h143, 1'b1, 8'h5A, 1'b0);
        txn_a(0, 1'b1, 9'h0FF, 8'h3C, 9'h0FF, 1'b0, 8'h00, 1'b0);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("dirty_eep0_w", {30'b0, dirty_a}, 32'h3);
`endif
        txn_a(2, 1'b0, 9'h0FF, 8'h00, 9'h0FF, 1'b1, 8'h3C, 1'b0);
        txn_a(2, 1'b1, 9'h17F, 8'h77, 9'h17F, 1'b0, 8'h00, 1'b0);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("dirty_host_w1", {30'b0, dirty_a}, 32'h3);
        @(negedge clk); dirty_clr_a = 2'b11;
        @(negedge clk); dirty_clr_a = 2'b00;
        @(negedge clk);
        chk_val("dirty_clr", {30'b0, dirty_a}, 32'h0);
`endif
        txn_a(1, 1'b0, 9'h0FF, 8'h00, 9'h17F, 1'b1, 8'h77, 1'b0);
        txn_a(0, 1'b1, 9'h020, 8'h11, 9'h020, 1'b0, 8'h00, 1'b1);
`ifdef EEP_DIRTY_TRACK_EN
        chk_val("dirty_set_wins", {30'b0, dirty_a}, 32'h1);
`endif

        // Round-robin from reset: all three held, expect 0,1,2,0,1,2.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            q_a.push_back('{idx: 0, chk_dat: 1'b1, dat: 8'hA5});
            q_a.push_back('{idx: 1, chk_dat: 1'b1, dat: 8'h5A});
            q_a.push_back('{idx: 2, chk_dat: 1'b1, dat: 8'h3C});
        end
        @(negedge clk);
        bus_a.we = 3'b000;
        bus_a.eep0_addr = 8'h10;
        bus_a.eep1_addr = 8'h43;
        bus_a.host_addr = 9'h0FF;
        bus_a.req = 3'b111;
        n = 0; cyc = 0; prev = 0;
        while (n < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_a.ack != 3'b000) begin
                n++;
                if (n == 1) chk_val("rr_first_lat", cyc, 2);
                else        chk_val("rr_spacing", cyc - prev, 2);
                prev = cyc;
            end
        end
        bus_a.req = 3'b000;
        chk_val("rr_acks", n, 6);
        repeat (3) @(negedge clk);
        chk_val("rr_queue_empty", q_a.size(), 0);

        // Reset during ISSUE of an eep1 write aborts it.
        @(negedge clk);
        bus_a.req[1] = 1'b1; bus_a.we[1] = 1'b1;
        bus_a.eep1_addr = 8'h43; bus_a.wdat1 = 8'hEE;
        @(negedge clk);
        chk_val("rstiss_we_before", {31'b0, bus_a.bram_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_val("rstiss_we_async", {31'b0, bus_a.bram_we}, 32'h0);
        chk_val("rstiss_addr", {23'b0, bus_a.bram_addr}, 32'h0);
        bus_a.req = 3'b000; bus_a.we = 3'b000;
        repeat (2) @(negedge clk);
        chk_val("rstiss_no_ack", {29'b0, bus_a.ack}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_val("rstiss_idle_ack", {29'b0, bus_a.ack}, 32'h0);
        chk_val("rstiss_idle_we", {31'b0, bus_a.bram_we}, 32'h0);
        txn_a(2, 1'b0, 9'h143, 8'h00, 9'h143, 1'b1, 8'h5A, 1'b0);

        repeat (3) @(negedge clk);
        chk_val("final_queue_a", q_a.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
